alu_arb_2r: RTL and testbench
=============================

ALU_ARB_2R -- requirements
Module: alu_arb_2r

Interface
REQ-001 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Port rst_n  in  1  reset, synchronous, active-low.
REQ-003 Ports r0_valid, r1_valid  in  1 each  requester n presents an operation.
REQ-004 Ports r0_ready, r1_ready  out  1 each  requester n's operation accepted this cycle.
REQ-005 Ports r0_a, r0_b, r1_a, r1_b  in  4 each  operands of requester n.
REQ-006 Ports r0_inst, r1_inst  in  4 each  operation code of requester n.
REQ-007 Port rsp_valid  out  1  result held and valid.
REQ-008 Port rsp_ready  in  1  consumer takes the result.
REQ-009 Port rsp_id  out  1  requester that issued the result (0 or 1).
REQ-010 Port rsp_data  out  4  result.
REQ-011 Port rsp_err  out  1  result came from divide or modulo by zero.
REQ-012 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; one operation in flight at a time; no queuing.
REQ-014 IDLE: if either valid is high, grant one requester, assert only its ready (combinational, this cycle), latch its a/b/inst, record its id, go to EXEC; otherwise stay in IDLE.
REQ-015 Arbitration: only one valid -> grant it; both valid -> grant the requester not granted last; last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-016 A requester holds its valid and operands until it sees its ready; valid dropped before grant is not an error.
REQ-017 EXEC: compute the result from the latched operands, register rsp_data/rsp_id/rsp_err, go to RESP (one cycle).
REQ-018 RESP: rsp_valid high; rsp_data/rsp_id/rsp_err stable; when rsp_ready is high, go to IDLE at that edge.
REQ-019 Latency: handshake at edge N -> rsp_valid high from cycle after edge N+1; minimum 3 cycles per operation; no acceptance outside IDLE.
REQ-020 inst[3]=0 (logic): inst[2:1] 00 zero, 01 a AND b, 10 a OR b, 11 a XOR b; inst[0]=1 -> logical NOT of that value (4'h1 if value zero, else 4'h0).
REQ-021 inst[3]=1 (arith, by inst[2:0]): 000 a+b, 001 a-b, 010 a*b, 011 a/b, 100 a%b, 101 a**b, 110/111 zero; all unsigned, result is low 4 bits (wrap).
REQ-022 b=0 with op 1011 or 1100: rsp_data=4'hF, rsp_err=1; every other case rsp_err=0.
REQ-023 a**b uses a**0=1, 0**b=0 for b>0, low 4 bits only.
REQ-024 rsp_ready while rsp_valid low: ignored.

Reset
REQ-025 rst_n low at an edge: state->IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, last-grant=1; both readys low while rst_n low.
REQ-026 Reset during EXEC or RESP discards the operation: no response, no ready pulse afterwards.

Verification
REQ-027 Single: r0 a=5 b=3 inst=1000 -> r0_ready 1 cycle, then rsp_valid, rsp_id=0, rsp_data=8, rsp_err=0.
REQ-028 Tie: both valid held, r0 inst=0010 a=C b=A, r1 inst=0110 a=C b=A -> first grant r0 (data=8), then r1 (data=6); repeated tie alternates.
REQ-029 Divide by zero: r1 a=7 b=0 inst=1011 -> rsp_data=F, rsp_err=1, rsp_id=1; then a=7 b=2 inst=1100 -> data=1, err=0.
REQ-030 Wrap and NOT: a=F b=2 inst=1000 -> 1; a=3 b=5 inst=1001 -> E; a=3 b=3 inst=1010 -> 9; a=3 b=3 inst=0111 -> 1.
REQ-031 Backpressure: rsp_ready low 5 cycles -> rsp_valid/data stable, both readys low, new valid not accepted until cycle after rsp_ready.
REQ-032 Reset mid-op: rst_n low in EXEC -> no rsp_valid; all outputs zero next cycle; tie afterwards granted to r0.

Source files
------------

// File: rtl/alu_arb_2r.sv
// Two-requester ALU front end: round-robin grant on ties, one operation in
// flight, registered response held in RESP until the consumer takes it.
module alu_arb_2r (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    input  logic       r1_valid,
    output logic       r0_ready,
    output logic       r1_ready,
    input  logic [3:0] r0_a,
    input  logic [3:0] r0_b,
    input  logic [3:0] r1_a,
    input  logic [3:0] r1_b,
    input  logic [3:0] r0_inst,
    input  logic [3:0] r1_inst,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       last_grant;
    logic       grant_id;
    logic       accept;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] op_inst;
    logic       op_id;
    logic [3:0] alu_data;
    logic       alu_err;

    // Unsigned power truncated to 4 bits; the loop bound covers every b.
    function automatic logic [3:0] pow4(input logic [3:0] base, input logic [3:0] exp_v);
        logic [3:0] acc;
        acc = 4'h1;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(exp_v)) begin
                acc = 4'(acc * base);
            end
        end
        return acc;
    endfunction

    // Tie goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant_id = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_id = ~last_grant;
        end else if (r1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept   = rst_n && (state == IDLE) && (r0_valid || r1_valid);
    assign r0_ready = accept && !grant_id;
    assign r1_ready = accept && grant_id;
    assign busy     = (state != IDLE);

    always_comb begin
        alu_data = 4'h0;
        alu_err  = 1'b0;
        if (!op_inst[3]) begin
            unique case (op_inst[2:1])
                2'b00: alu_data = 4'h0;
                2'b01: alu_data = op_a & op_b;
                2'b10: alu_data = op_a | op_b;
                2'b11: alu_data = op_a ^ op_b;
                default: alu_data = 4'h0;
            endcase
            if (op_inst[0]) begin
                alu_data = (alu_data == 4'h0) ? 4'h1 : 4'h0;
            end
        end else begin
            unique case (op_inst[2:0])
                3'b000: alu_data = op_a + op_b;
                3'b001: alu_data = op_a - op_b;
                3'b010: alu_data = 4'(op_a * op_b);
                3'b011: begin
                    if (op_b == 4'h0) begin
                        alu_data = 4'hF;
                        alu_err  = 1'b1;
                    end else begin
                        alu_data = op_a / op_b;
                    end
                end
                3'b100: begin
                    if (op_b == 4'h0) begin
                        alu_data = 4'hF;
                        alu_err  = 1'b1;
                    end else begin
                        alu_data = op_a % op_b;
                    end
                end
                3'b101:  alu_data = pow4(op_a, op_b);
                default: alu_data = 4'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= 4'h0;
            op_b       <= 4'h0;
            op_inst    <= 4'h0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 4'h0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant_id ? r1_a : r0_a;
                        op_b       <= grant_id ? r1_b : r0_b;
                        op_inst    <= grant_id ? r1_inst : r0_inst;
                        op_id      <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_data;
                    rsp_err   <= alu_err;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb_2r.sv
// Directed bench for alu_arb_2r: reset, tie alternation, an ALU vector table,
// backpressure and reset in the middle of an operation.
module tb_alu_arb_2r;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_valid, r1_valid, r0_ready, r1_ready;
    logic [3:0] r0_a, r0_b, r1_a, r1_b, r0_inst, r1_inst;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [3:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arb_2r dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
        .r0_inst(r0_inst), .r1_inst(r1_inst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] inst;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] inst);
        if (id) begin
            r1_valid = 1'b1; r1_a = a; r1_b = b; r1_inst = inst;
        end else begin
            r0_valid = 1'b1; r0_a = a; r0_b = b; r0_inst = inst;
        end
    endtask

    // Called at the negedge right after the handshake edge (DUT in EXEC).
    task automatic finish_resp(input string tag, input logic id, input logic [3:0] data,
                               input logic err);
        check({tag, " exec rsp_valid"}, 8'(rsp_valid), 8'h0);
        check({tag, " exec busy"}, 8'(busy), 8'h1);
        @(posedge clk);
        @(negedge clk);
        check({tag, " rsp_valid"}, 8'(rsp_valid), 8'h1);
        check({tag, " rsp_id"}, 8'(rsp_id), 8'(id));
        check({tag, " rsp_data"}, 8'(rsp_data), 8'(data));
        check({tag, " rsp_err"}, 8'(rsp_err), 8'(err));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, 8'(rsp_valid), 8'h0);
        check({tag, " idle busy"}, 8'(busy), 8'h0);
    endtask

    task automatic do_op(input string tag, input vec_t v);
        drive_req(v.id, v.a, v.b, v.inst);
        #1;
        check({tag, " r0_ready"}, 8'(r0_ready), 8'(!v.id));
        check({tag, " r1_ready"}, 8'(r1_ready), 8'(v.id));
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        finish_resp(tag, v.id, v.exp_data, v.exp_err);
    endtask

    // Both requesters valid; the expected winner drops valid after its grant.
    task automatic tie_round(input string tag, input logic win, input logic [3:0] data);
        drive_req(1'b0, 4'hC, 4'hA, 4'b0010);
        drive_req(1'b1, 4'hC, 4'hA, 4'b0110);
        #1;
        check({tag, " r0_ready"}, 8'(r0_ready), 8'(!win));
        check({tag, " r1_ready"}, 8'(r1_ready), 8'(win));
        @(posedge clk);
        @(negedge clk);
        if (win) r1_valid = 1'b0; else r0_valid = 1'b0;
        #1;
        check({tag, " no ready in exec"}, 8'({r0_ready, r1_ready}), 8'h0);
        finish_resp(tag, win, data, 1'b0);
    endtask

    initial begin
        vecs.push_back('{1'b0, 4'h5, 4'h3, 4'b1000, 4'h8, 1'b0});
        vecs.push_back('{1'b1, 4'h7, 4'h0, 4'b1011, 4'hF, 1'b1});
        vecs.push_back('{1'b1, 4'h7, 4'h2, 4'b1100, 4'h1, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'h2, 4'b1000, 4'h1, 1'b0});
        vecs.push_back('{1'b0, 4'h3, 4'h5, 4'b1001, 4'hE, 1'b0});
        vecs.push_back('{1'b1, 4'h3, 4'h3, 4'b1010, 4'h9, 1'b0});
        vecs.push_back('{1'b0, 4'h3, 4'h3, 4'b0111, 4'h1, 1'b0});
        vecs.push_back('{1'b0, 4'hA, 4'h5, 4'b0100, 4'hF, 1'b0});
        vecs.push_back('{1'b1, 4'h6, 4'h3, 4'b0011, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h2, 4'h3, 4'b1101, 4'h8, 1'b0});
        vecs.push_back('{1'b1, 4'h0, 4'h0, 4'b1101, 4'h1, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 4'h3, 4'b1101, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 4'h3, 4'h3, 4'b1101, 4'hB, 1'b0});
        vecs.push_back('{1'b0, 4'h9, 4'h0, 4'b1100, 4'hF, 1'b1});
        vecs.push_back('{1'b1, 4'h5, 4'h5, 4'b1110, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h9, 4'h2, 4'b0000, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h9, 4'h4, 4'b0001, 4'h1, 1'b0});
        vecs.push_back('{1'b1, 4'hE, 4'h3, 4'b1011, 4'h4, 1'b0});

        rst_n = 1'b0; rsp_ready = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        r0_a = 4'h0; r0_b = 4'h0; r0_inst = 4'h0;
        r1_a = 4'h0; r1_b = 4'h0; r1_inst = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset readys", 8'({r0_ready, r1_ready}), 8'h0);
        check("reset rsp_valid", 8'(rsp_valid), 8'h0);
        check("reset rsp_data", 8'(rsp_data), 8'h0);
        check("reset rsp_id/err", 8'({rsp_id, rsp_err}), 8'h0);
        check("reset busy", 8'(busy), 8'h0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        tie_round("tie1", 1'b0, 4'h8);
        tie_round("tie2", 1'b1, 4'h6);
        tie_round("tie3", 1'b0, 4'h8);
        tie_round("tie4", 1'b1, 4'h6);

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: response held for five cycles while r1 waits.
        drive_req(1'b0, 4'h5, 4'h3, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b1, 4'h2, 4'h2, 4'b1010);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d rsp_valid", c), 8'(rsp_valid), 8'h1);
            check($sformatf("bp%0d rsp_data", c), 8'(rsp_data), 8'h8);
            check($sformatf("bp%0d readys", c), 8'({r0_ready, r1_ready}), 8'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp release same cycle r1_ready", 8'(r1_ready), 8'h0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("bp after release rsp_valid", 8'(rsp_valid), 8'h0);
        check("bp after release r1_ready", 8'(r1_ready), 8'h1);
        @(posedge clk);
        @(negedge clk);
        r1_valid = 1'b0;
        finish_resp("bp r1", 1'b1, 4'h4, 1'b0);

        // Reset in EXEC after granting r0: operation discarded, pointer restored.
        drive_req(1'b0, 4'h5, 4'h3, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        rst_n = 1'b0;
        r1_valid = 1'b1;
        #1;
        check("midrst readys while low", 8'({r0_ready, r1_ready}), 8'h0);
        @(posedge clk);
        @(negedge clk);
        check("midrst rsp_valid", 8'(rsp_valid), 8'h0);
        check("midrst rsp_data", 8'(rsp_data), 8'h0);
        check("midrst busy", 8'(busy), 8'h0);
        r1_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst no late response", 8'(rsp_valid), 8'h0);
        end
        tie_round("post-reset tie", 1'b0, 4'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
